// File: rtl/modemux_pkg.sv
// Shared definitions for the modemux arbiter and the modedemux distributor:
// lane count, lane index type, mode encodings and the round-robin lane search.
package modemux_pkg;

    localparam int NLANES = 4;

    typedef logic [1:0] lane_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // First lane at or after ptr (modulo NLANES) whose bit in full is clear.
    function automatic lane_t rr_pick(input lane_t ptr, input logic [NLANES-1:0] full);
        lane_t cand;
        rr_pick = ptr;
        for (int k = NLANES - 1; k >= 0; k--) begin
            cand = lane_t'(ptr + lane_t'(k));
            if (!full[cand]) rr_pick = cand;
        end
    endfunction

endpackage

// File: rtl/modedemux_fifo.sv
// Per-lane FIFO for modedemux: DEPTH entries of DW bits, head word always
// visible on dout, storage cleared by the asynchronous active-low reset.
module demux_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // NOTE: the storage array is reset because a cleared head word must show
    // on dout after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/modedemux.sv
// Four-lane distributor: routes one source stream to per-lane FIFOs, by
// destination tag or round-robin. Define MODEDEMUX_CNT_EN to add xfer_cnt.
module modedemux
    import modemux_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    input  lane_t             in_dest,
    output logic              in_ready,
    input  logic [NLANES-1:0] out_ready,
    output logic [NLANES-1:0] out_valid,
    output logic [DW-1:0]     out_data0,
    output logic [DW-1:0]     out_data1,
    output logic [DW-1:0]     out_data2,
    output logic [DW-1:0]     out_data3,
    output lane_t             last_lane
`ifdef MODEDEMUX_CNT_EN
    ,
    output logic [15:0]       xfer_cnt
`endif
);

    logic [NLANES-1:0] full;
    logic [NLANES-1:0] empty;
    logic [NLANES-1:0] push;
    logic [NLANES-1:0] pop;
    logic [DW-1:0]     lane_data [NLANES];
    lane_t             rr_ptr;
    lane_t             sel;
    logic              accept;

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sel      = in_dest;
        in_ready = 1'b0;
        if (rst) begin
            if (mode == MODE_RR) begin
                sel      = rr_pick(rr_ptr, full);
                in_ready = ~&full;
            end else if (mode == MODE_FIXED) begin
                in_ready = ~full[in_dest];
            end
        end
    end

    assign accept = in_valid && in_ready;

    // in_ready depends only on registered fullness, so a lane popped on the
    // same edge it is full still refuses the incoming word.
    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        assign push[i] = accept && (sel == lane_t'(i));
        assign pop[i]  = !empty[i] && out_ready[i];

        demux_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .din   (in_data),
            .pop   (pop[i]),
            .dout  (lane_data[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    assign out_valid = ~empty;
    assign out_data0 = lane_data[0];
    assign out_data1 = lane_data[1];
    assign out_data2 = lane_data[2];
    assign out_data3 = lane_data[3];

    // The pointer advances only on round-robin accepts and survives mode changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            last_lane <= '0;
        end else if (accept) begin
            last_lane <= sel;
            if (mode == MODE_RR) rr_ptr <= lane_t'(sel + lane_t'(1));
        end
    end

`ifdef MODEDEMUX_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        xfer_cnt <= '0;
        else if (accept) xfer_cnt <= xfer_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_modedemux.sv
// Scoreboard bench for modedemux: directed words push expected data per lane,
// a negedge monitor pops and compares every word the DUT hands downstream.
module tb_modedemux;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic       in_ready;
    logic [3:0] out_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
    logic [1:0] last_lane;
`ifdef MODEDEMUX_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    logic [7:0] od [4];
    logic [7:0] sb [4][$];
    int n_cmp = 0;
    int n_bad = 0;

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    modedemux #(.DW(8), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .last_lane (last_lane)
`ifdef MODEDEMUX_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at negedge completes at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (sb[i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL lane%0d_unexpected: got %0h expected none", i, od[i]);
                    end else begin
                        check($sformatf("lane%0d_data", i), {24'd0, od[i]}, {24'd0, sb[i].pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Called at posedge+1; holds the word for one edge.
    task automatic send(input logic [7:0] d, input logic m, input logic [1:0] dest,
                        input logic [1:0] exp_lane, input logic exp_rdy);
        mode     = m;
        in_data  = d;
        in_dest  = dest;
        in_valid = 1'b1;
        @(negedge clk);
        check($sformatf("in_ready_%0h", d), {31'd0, in_ready}, {31'd0, exp_rdy});
        if (exp_rdy) sb[exp_lane].push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (exp_rdy) check($sformatf("last_lane_%0h", d), {30'd0, last_lane}, {30'd0, exp_lane});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe_ready(input logic m, input logic [1:0] dest, input logic exp, input string name);
        mode    = m;
        in_dest = dest;
        #1;
        check(name, {31'd0, in_ready}, {31'd0, exp});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, {28'd0, out_valid}, 32'h0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'h0);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_data%0d", tag, i), {24'd0, od[i]}, 32'h0);
    endtask

    task automatic drain_all(input string tag);
        out_ready = 4'b1111;
        cycles(4);
        out_ready = 4'b0000;
        check({tag, "_drained"}, {28'd0, out_valid}, 32'h0);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_sb%0d_left", tag, i), sb[i].size(), 32'd0);
    endtask

    initial begin
        logic [7:0] rr_words [8];
        logic [7:0] first [4];
        rr_words = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        first    = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

        // Reset held with a word offered: nothing may be accepted.
        rst = 1'b0; mode = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_dest = 2'd0; out_ready = 4'b0000;
        #12;
        check_cleared("reset");
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Round-robin spread with every sink ready.
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) send(rr_words[i], 1'b1, 2'd3, 2'(i % 4), 1'b1);
        drain_all("rr_spread");

        // Addressed mode, sinks stalled.
        for (int i = 0; i < 4; i++) send(first[i], 1'b0, 2'(i), 2'(i), 1'b1);
        check("addr_valid", {28'd0, out_valid}, 32'hF);
        for (int i = 0; i < 4; i++)
            check($sformatf("addr_head%0d", i), {24'd0, od[i]}, {24'd0, first[i]});
        send(8'hA4, 1'b0, 2'd0, 2'd0, 1'b1);
        send(8'hB5, 1'b0, 2'd1, 2'd1, 1'b1);
        send(8'hC6, 1'b0, 2'd2, 2'd2, 1'b1);
        probe_ready(1'b0, 2'd2, 1'b0, "addr_full2_ready");
        probe_ready(1'b0, 2'd3, 1'b1, "addr_open3_ready");
        send(8'hD7, 1'b0, 2'd3, 2'd3, 1'b1);
        send(8'hC8, 1'b0, 2'd2, 2'd2, 1'b0);
        probe_ready(1'b1, 2'd0, 1'b0, "rr_allfull_ready");

        // Drain lanes 0, 2, 3 so only lane 1 stays full; rr_ptr is still 0.
        out_ready = 4'b1101;
        cycles(3);
        out_ready = 4'b0000;
        check("partial_drain_valid", {28'd0, out_valid}, 32'h2);

        // Round-robin skipping the full lane 1.
        send(8'h20, 1'b1, 2'd1, 2'd0, 1'b1);
        send(8'h21, 1'b1, 2'd1, 2'd2, 1'b1);
        send(8'h22, 1'b1, 2'd1, 2'd3, 1'b1);
        send(8'h23, 1'b1, 2'd1, 2'd0, 1'b1);
        send(8'h24, 1'b1, 2'd1, 2'd2, 1'b1);
        send(8'h25, 1'b1, 2'd1, 2'd3, 1'b1);
        send(8'h26, 1'b1, 2'd0, 2'd0, 1'b0);
        probe_ready(1'b0, 2'd3, 1'b0, "addr_allfull_ready");

        // Free one slot in lane 0, refill it so rr_ptr moves to 1, then reset mid-operation.
        out_ready = 4'b0001;
        cycles(1);
        out_ready = 4'b0000;
        send(8'h27, 1'b1, 2'd2, 2'd0, 1'b1);
        rst = 1'b0;
        #1;
        check_cleared("midreset");
        for (int i = 0; i < 4; i++) sb[i].delete();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // rr_ptr must restart at 0 after reset.
        send(8'h30, 1'b1, 2'd2, 2'd0, 1'b1);

        // Push and pop lane 0 on the same edge at occupancy 1.
        out_ready = 4'b0001;
        send(8'h31, 1'b0, 2'd0, 2'd0, 1'b1);
        out_ready = 4'b0000;
        check("pushpop_valid", {28'd0, out_valid}, 32'h1);
        check("pushpop_head", {24'd0, out_data0}, 32'h31);
        probe_ready(1'b0, 2'd0, 1'b1, "pushpop_not_full");
        drain_all("final");

`ifdef MODEDEMUX_CNT_EN
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("cnt_reset", {16'd0, xfer_cnt}, 32'h0);
        out_ready = 4'b1111;
        for (int i = 0; i < 65535; i++) send(8'(i), 1'b1, 2'd0, 2'(i % 4), 1'b1);
        check("cnt_ffff", {16'd0, xfer_cnt}, 32'hFFFF);
        send(8'hEE, 1'b1, 2'd0, 2'd3, 1'b1);
        check("cnt_wrap", {16'd0, xfer_cnt}, 32'h0);
        drain_all("cnt");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
